// File: rtl/sipo_deframer.sv
// sipo_deframer
//   Collects framed serial bits into WIDTH-bit words and hands each completed
//   word to a downstream holding register over a valid/ready parallel port.
//   A start-of-frame marker aligns every word. One completed word is buffered.
//   Sticky status bits report dropped words and sof arriving mid-word.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   si_valid   qualifies si/sof
//   si         serial data bit
//   sof        accepted bit is bit 0 of a new word
//   po         parallel word (held while undelivered, keeps last value after)
//   po_valid   po holds an undelivered word
//   po_ready   downstream takes po at this edge
//   clr_err    clears overrun/frame_err (a coincident set event wins)
//   overrun    sticky: completed word dropped because po was still full
//   frame_err  sticky: sof arrived while a word was partially collected
module sipo_deframer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             si_valid,
    input  logic             si,
    input  logic             sof,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    input  logic             clr_err,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [WIDTH-1:0]  sr, sr_nxt;
    logic [WIDTH-1:0]  first_bit;   // sr image holding only bit 0 of a new word
    logic [WIDTH-1:0]  shifted;     // sr with si appended; the full word on completion
    logic              done;        // WIDTH-th bit accepted this cycle
    logic              restart;     // sof seen while mid-word
    logic              load;

    // MSB-first shifts left so the first bit ends in po[WIDTH-1];
    // LSB-first shifts right so the first bit ends in po[0].
    assign first_bit = MSB_FIRST ? {{(WIDTH-1){1'b0}}, si} : {si, {(WIDTH-1){1'b0}}};
    assign shifted   = MSB_FIRST ? {sr[WIDTH-2:0], si}     : {si, sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        done      = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                // bits without sof are dropped until alignment is found
                if (si_valid && sof) begin
                    sr_nxt    = first_bit;
                    cnt_nxt   = CW'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (si_valid) begin
                    if (sof) begin
                        restart = 1'b1;
                        sr_nxt  = first_bit;
                        cnt_nxt = CW'(1);
                    end else if (cnt == CW'(WIDTH-1)) begin
                        done      = 1'b1;
                        sr_nxt    = shifted;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        sr_nxt  = shifted;
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A finished word may load when the buffer is empty or is being drained
    // at the same edge; otherwise the new word is the one that gets dropped.
    assign load = done && (!po_valid || po_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            po        <= '0;
            po_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (load)
                po <= shifted;
            po_valid  <= load | (po_valid & ~po_ready);
            overrun   <= (done & po_valid & ~po_ready) | (overrun & ~clr_err);
            frame_err <= restart | (frame_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: one MSB-first and one LSB-first instance share the
// same stimulus. A queue-based reference model of the framing rules pushes
// expected words; a negedge monitor checks status and pops on handshake.
module tb_sipo_deframer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         si_valid = 1'b0, si = 1'b0, sof = 1'b0;
    logic         po_ready = 1'b0, clr_err = 1'b0;
    logic [W-1:0] po_m, po_l;
    logic         pv_m, pv_l, ovr_m, ovr_l, fe_m, fe_l;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .si_valid(si_valid), .si(si), .sof(sof),
        .po(po_m), .po_valid(pv_m), .po_ready(po_ready), .clr_err(clr_err),
        .overrun(ovr_m), .frame_err(fe_m));

    sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .si_valid(si_valid), .si(si), .sof(sof),
        .po(po_l), .po_valid(pv_l), .po_ready(po_ready), .clr_err(clr_err),
        .overrun(ovr_l), .frame_err(fe_l));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [W-1:0] m; logic [W-1:0] l; } word_t;
    word_t expq[$];
    bit    bits[$];        // bits of the word being collected, in arrival order
    bit    mbuf = 1'b0;    // model: a word is waiting downstream
    bit    m_ovr = 1'b0, m_fe = 1'b0;
    logic [W-1:0] last_m = '0, last_l = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bits.delete();
            expq.delete();
            mbuf   = 1'b0;
            m_ovr  = 1'b0;
            m_fe   = 1'b0;
            last_m = '0;
            last_l = '0;
        end else begin
            bit    ovr_set, fe_set, done;
            word_t w;
            ovr_set = 0; fe_set = 0; done = 0;
            w.m = '0; w.l = '0;
            if (si_valid) begin
                if (sof) begin
                    if (bits.size() != 0) fe_set = 1;
                    bits.delete();
                    bits.push_back(si);
                end else if (bits.size() != 0) begin
                    bits.push_back(si);
                    if (bits.size() == W) begin
                        done = 1;
                        for (int i = 0; i < W; i++) begin
                            w.m[W-1-i] = bits[i];
                            w.l[i]     = bits[i];
                        end
                        bits.delete();
                    end
                end
            end
            if (done) begin
                if (!mbuf || po_ready) begin
                    expq.push_back(w);
                    mbuf = 1;
                end else begin
                    ovr_set = 1;
                end
            end else if (mbuf && po_ready) begin
                mbuf = 0;
            end
            m_ovr = ovr_set ? 1'b1 : (clr_err ? 1'b0 : m_ovr);
            m_fe  = fe_set  ? 1'b1 : (clr_err ? 1'b0 : m_fe);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            chk("po_valid_msb", pv_m, mbuf);
            chk("po_valid_lsb", pv_l, mbuf);
            chk("overrun_msb", ovr_m, m_ovr);
            chk("overrun_lsb", ovr_l, m_ovr);
            chk("frame_err_msb", fe_m, m_fe);
            chk("frame_err_lsb", fe_l, m_fe);
            if (mbuf) begin
                if (expq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_empty: po_valid=%0b but no expected word", pv_m);
                end else begin
                    chk("po_msb", po_m, expq[0].m);
                    chk("po_lsb", po_l, expq[0].l);
                    if (po_ready) begin
                        last_m = expq[0].m;
                        last_l = expq[0].l;
                        void'(expq.pop_front());
                    end
                end
            end else begin
                chk("po_hold_msb", po_m, last_m);
                chk("po_hold_lsb", po_l, last_l);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic d, input logic f);
        si_valid = v; si = d; sof = f;
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic [W-1:0] b);   // b[W-1] is sent first
        for (int i = W-1; i >= 0; i--)
            drive(1'b1, b[i], i == W-1);
    endtask

    initial begin
        #3;
        chk("rst_po_valid", pv_m, 1'b0);
        chk("rst_po", po_m, '0);
        chk("rst_overrun", ovr_m, 1'b0);
        chk("rst_frame_err", fe_l, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // basic frame, zero-stall
        po_ready = 1'b1;
        frame(4'b1011);
        chk("t1_valid", pv_m, 1'b1);
        chk("t1_po_msb", po_m, 4'b1011);
        chk("t1_po_lsb", po_l, 4'b1101);
        drive(1'b0, 1'b0, 1'b0);
        chk("t1_valid_clr", pv_m, 1'b0);
        chk("t1_flags", {ovr_m, fe_m}, 2'b00);

        // gaps in si_valid
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        chk("t3_not_yet", pv_m, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        chk("t3_valid", pv_m, 1'b1);
        chk("t3_po", po_m, 4'b0110);
        drive(1'b0, 1'b0, 1'b0);

        // overrun
        po_ready = 1'b0;
        frame(4'b1010);
        frame(4'b0101);
        chk("t4_overrun", ovr_m, 1'b1);
        chk("t4_po_held", po_m, 4'b1010);
        po_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("t4_delivered", pv_m, 1'b0);
        clr_err = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        clr_err = 1'b0;
        chk("t4_cleared", ovr_m, 1'b0);

        // sof mid-word
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        frame(4'b0011);
        chk("t5_frame_err", fe_m, 1'b1);
        chk("t5_po_msb", po_m, 4'b0011);
        chk("t5_po_lsb", po_l, 4'b1100);
        clr_err = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        clr_err = 1'b0;

        // async reset with a buffered word and a partial word
        po_ready = 1'b0;
        frame(4'b1010);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_valid", pv_m, 1'b0);
        chk("t6_async_po", po_m, '0);
        chk("t6_async_flags", {ovr_m, fe_m}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b1;
        po_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        chk("t6_discard", pv_m, 1'b0);
        frame(4'b1100);
        chk("t6_valid", pv_m, 1'b1);
        chk("t6_po", po_m, 4'b1100);
        chk("t6_no_err", fe_m, 1'b0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            si_valid = ($urandom % 4) != 0;
            si       = $urandom % 2;
            sof      = ($urandom % 6) == 0;
            po_ready = (c > 2200) ? 1'b1 : (($urandom % 3) != 0);
            clr_err  = ($urandom % 20) == 0;
            if (($urandom % 500) == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
            @(posedge clk); #1;
        end
        si_valid = 1'b0; sof = 1'b0; clr_err = 1'b0; po_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_deframer.md
# sipo_deframer

Serial-in, parallel-out deframer that sits directly upstream of the parallel holding register stage. It collects framed serial bits into WIDTH-bit words and presents each word on a valid/ready parallel output that drives the holding register's parallel input. The block tracks frame alignment with a start-of-frame marker, buffers one completed word, and flags overruns and framing errors with sticky status bits.

## Interface
- WIDTH, 4: word width in bits; legal range 2..16.
- MSB_FIRST, 1: 1 = first serial bit lands in po[WIDTH-1]; 0 = first bit lands in po[0].

- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- si_valid  input  1  qualifies si and sof; a bit is accepted only when 1.
- si  input  1  serial data bit.
- sof  input  1  start-of-frame; marks the accepted bit as bit 0 of a new word.
- po  output  WIDTH  parallel word to downstream register.
- po_valid  output  1  po holds an undelivered word.
- po_ready  input  1  downstream accepts po at this edge.
- clr_err  input  1  clears overrun and frame_err.
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: sof arrived mid-word.

## Operation
- States: IDLE (no partial word) and SHIFT (1..WIDTH-1 bits collected); bit counter cnt, shift register sr, output register po.
- IDLE: si_valid=1 and sof=1 -> store si as bit 0, cnt=1, go SHIFT. si_valid=1 with sof=0 -> bit discarded, stay IDLE.
- SHIFT, si_valid=1, sof=0: shift si in (MSB_FIRST selects direction), cnt+1. When this is the WIDTH-th bit: word complete, go IDLE, cnt=0.
- SHIFT, si_valid=1, sof=1: discard partial word, set frame_err, restart with this bit as bit 0, cnt=1, stay SHIFT.
- si_valid=0: no state change in either state.
- Word completion: if po_valid=0, or po_valid=1 and po_ready=1 at the same edge, load po with completed word, po_valid=1. Otherwise (po_valid=1, po_ready=0) drop new word, keep po unchanged, set overrun.
- Output handshake: po_valid and po_ready high at an edge -> word delivered; po_valid clears unless a new word loads at the same edge.
- po held stable while po_valid=1 and po_ready=0; po keeps last delivered value after po_valid falls.
- Sticky flags: clr_err=1 clears both flags; if a set event coincides with clr_err, set wins.
- Bit order example, WIDTH=4: serial 1,0,1,1 -> po=4'b1011 (MSB_FIRST=1) or 4'b1101 (MSB_FIRST=0).

## Timing
- Reset (reset=0, async): state IDLE, cnt=0, sr=0, po=0, po_valid=0, overrun=0, frame_err=0; all take effect immediately, independent of clk.
- Reset mid-word or with po_valid=1: partial word and buffered word lost, no flags set.
- Latency: last bit accepted at edge N -> po_valid=1 and po valid after edge N (visible in cycle N+1).
- Minimum word period: WIDTH accepted bits; back-to-back frames legal (sof on the cycle after completion is accepted in IDLE).
- po_ready is ignored when po_valid=0; po_ready may be held high permanently for zero-stall operation.
- Flags update on the edge of the causing event; visible next cycle.

## Test plan
- Reset then frame 1,0,1,1 (sof on first bit), po_ready=1 -> po=4'b1011, po_valid high exactly one cycle after 4th bit, cleared next edge; flags 0.
- MSB_FIRST=0, same frame -> po=4'b1101.
- si_valid gaps: bits 0,1 then two idle cycles then 1,0 -> po=4'b0110, latency measured from 4th accepted bit.
- po_ready=0, frame 4'b1010 then frame 4'b0101 -> po stays 4'b1010, overrun=1; raise po_ready -> 4'b1010 delivered; clr_err -> overrun=0.
- sof asserted on 3rd bit of frame 1,1,x then 0,0,1,1 -> frame_err=1, po=4'b0011 (first two bits dropped).
- reset low while cnt=2 and po_valid=1 -> outputs 0 asynchronously; after release, a bit without sof is discarded and next sof frame completes normally.
